// File: rtl/edma_arb_pkg.sv
// edma_pkg: shared definitions for the emesh DMA output arbiter.
//   - FSM state encoding for edma_arb (IDLE / SEND / STALL)
//   - standard emesh packet width derivation
//   - requester index constants
package edma_pkg;

    // Bit 0 is set in every state that holds a valid output packet, so the
    // arbiter's access_out comes straight off a state flop. SEND <-> STALL
    // changes only bit 1, so access_out never glitches on a stall.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SEND  = 2'b01;
    localparam logic [1:0] STALL = 2'b11;

    // Requester slots: the DMA datapath has the lowest index, so it wins
    // the first arbitration after reset.
    localparam int REQ_DMA = 0;
    localparam int REQ_REG = 1;

    // Standard emesh packet: two address-wide fields plus 40 control/data bits.
    function automatic int pkt_width(input int aw);
        return 2 * aw + 40;
    endfunction

endpackage

// File: rtl/edma_arb_if.sv
// edma_arb_if: requester/downstream bundle for the emesh DMA arbiter.
//   access_in  [N]     per-requester packet valid
//   packet_in  [N*PW]  requester i at bits [i*PW +: PW]
//   wait_out   [N]     per-requester stall back to the requesters
//   access_out         registered output valid
//   packet_out [PW]    registered output packet
//   wait_in            downstream stall
//   grant_out  [N]     one-hot owner of the packet in the output register
// Modports: slave = the arbiter, master = requesters plus downstream sink.
interface edma_arb_if
    import edma_pkg::*;
#(
    parameter int AW = 32,
    parameter int N  = 2
);
    localparam int PW = pkt_width(AW);

    logic [N-1:0]    access_in;
    logic [N*PW-1:0] packet_in;
    logic [N-1:0]    wait_out;
    logic            access_out;
    logic [PW-1:0]   packet_out;
    logic            wait_in;
    logic [N-1:0]    grant_out;

    modport slave (
        input  access_in, packet_in, wait_in,
        output wait_out, access_out, packet_out, grant_out
    );

    modport master (
        output access_in, packet_in, wait_in,
        input  wait_out, access_out, packet_out, grant_out
    );

endinterface

// File: rtl/oh_rrarb.sv
// oh_rrarb: rotating-priority one-hot selector.
//   req   [N]     request vector
//   ptr   [PTRW]  index with highest priority this cycle (0..N-1)
//   grant [N]     one-hot winner, or zero when no request is set
// Priority runs upward from ptr, wrapping modulo N.
module oh_rrarb #(
    parameter int N    = 2,
    parameter int PTRW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [PTRW-1:0] ptr,
    output logic [N-1:0]    grant
);

    logic [N-1:0] req_rot;
    logic [N-1:0] first_rot;

    // Rotate right by ptr so the priority slot lands on bit 0; bit j of
    // req_rot is then req[(ptr + j) mod N].
    assign req_rot   = N'({req, req} >> ptr);

    // Isolate the lowest set bit: x & -x.
    assign first_rot = req_rot & (~req_rot + N'(1));

    // Rotate back left by ptr; the upper half of the doubled vector holds
    // the wrapped result.
    assign grant     = N'(({first_rot, first_rot} << ptr) >> N);

endmodule

// File: rtl/edma_arb.sv
// edma_arb: N-way round-robin arbiter feeding one registered emesh output.
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    edma_arb_if.slave: access_in/packet_in/wait_out towards the
//          requesters, access_out/packet_out/wait_in/grant_out downstream
// The output register reloads whenever it is empty or downstream accepts,
// so an unstalled stream moves at one packet per cycle with one cycle of
// latency. Packets pass through untouched.
module edma_arb
    import edma_pkg::*;
#(
    parameter int AW = 32,
    parameter int N  = 2
) (
    input  logic     clk,
    input  logic     reset,
    edma_arb_if.slave bus
);

    localparam int PW   = pkt_width(AW);
    localparam int PTRW = $clog2(N);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [PTRW-1:0] ptr;
    logic [PTRW-1:0] ptr_nxt;
    logic            load;
    logic [N-1:0]    req_arb;
    logic [N-1:0]    grant;
    logic [PTRW-1:0] grant_idx;
    logic [PW-1:0]   grant_pkt;

    assign bus.access_out = state[0];

    // Output register is free when empty or being drained this cycle.
    assign load = ~bus.access_out | ~bus.wait_in;

    // Requests only reach the selector when the register can take a packet;
    // while reset is held nobody is granted, so every active requester waits.
    assign req_arb = bus.access_in & {N{load & ~reset}};

    oh_rrarb #(
        .N    (N),
        .PTRW (PTRW)
    ) u_rrarb (
        .req   (req_arb),
        .ptr   (ptr),
        .grant (grant)
    );

    assign bus.wait_out = bus.access_in & ~grant;

    // One-hot to index plus packet mux. grant is one-hot or zero, so an
    // OR of the selected lanes is an exact mux.
    // NOTE: every always_comb output gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    always_comb begin
        grant_idx = '0;
        grant_pkt = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = PTRW'(i);
                grant_pkt = grant_pkt | bus.packet_in[i*PW +: PW];
            end
        end
    end

    // Priority moves to the slot just after the winner.
    assign ptr_nxt = (grant_idx == PTRW'(N - 1)) ? '0 : grant_idx + PTRW'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|grant) state_nxt = SEND;
            end
            SEND: begin
                if (bus.wait_in)  state_nxt = STALL;
                else if (~|grant) state_nxt = IDLE;
            end
            STALL: begin
                // The stalled packet drains the cycle wait_in drops, and a
                // fresh grant can refill the register in that same cycle.
                if (~bus.wait_in) state_nxt = (|grant) ? SEND : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= PTRW'(REQ_DMA);
            bus.grant_out  <= '0;
            bus.packet_out <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                bus.grant_out <= grant;
                if (|grant) begin
                    bus.packet_out <= grant_pkt;
                    ptr            <= ptr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_edma_arb.sv
// tb_edma_arb: self-checking bench for edma_arb.
// Two instances share clk/reset: dut_a (N=2, AW=32) and dut_b (N=4, AW=8).
// A behavioural model tracks, per instance, whether the output register is
// full, what it holds, who owns it and the rotating start index; expected
// values come from the arbitration rules evaluated with plain integers.
module tb_edma_arb;
    import edma_pkg::*;

    localparam int AW_A = 32;
    localparam int N_A  = 2;
    localparam int AW_B = 8;
    localparam int N_B  = 4;
    localparam int PW_A = pkt_width(AW_A);
    localparam int PW_B = pkt_width(AW_B);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    edma_arb_if #(.AW(AW_A), .N(N_A)) a_if ();
    edma_arb_if #(.AW(AW_B), .N(N_B)) b_if ();

    edma_arb #(.AW(AW_A), .N(N_A)) dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
    edma_arb #(.AW(AW_B), .N(N_B)) dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

    typedef struct {
        int           ptr;
        bit           valid;
        logic [103:0] pkt;
        logic [7:0]   gmask;
    } model_t;

    model_t m[2];
    int     n_vec;
    int     n_err;

    task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input int d);
        return (d == 0) ? N_A : N_B;
    endfunction

    function automatic logic [7:0] get_acc(input int d);
        return (d == 0) ? 8'(a_if.access_in) : 8'(b_if.access_in);
    endfunction

    function automatic bit get_wi(input int d);
        return (d == 0) ? a_if.wait_in : b_if.wait_in;
    endfunction

    function automatic logic [103:0] get_pkt(input int d, input int i);
        if (d == 0) return a_if.packet_in[i*PW_A +: PW_A];
        return 104'(b_if.packet_in[i*PW_B +: PW_B]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m[d].ptr   = 0;
            m[d].valid = 1'b0;
            m[d].pkt   = '0;
            m[d].gmask = '0;
        end
    endtask

    // Evaluate one cycle of the arbitration rules for instance d: returns the
    // expected wait_out for the current inputs and advances m[d] to the state
    // the next rising edge must produce.
    task automatic model_eval(input int d, output logic [7:0] ew);
        int         n;
        int         w;
        logic [7:0] acc;
        n   = n_of(d);
        acc = get_acc(d);
        w   = -1;
        if (reset) begin
            m[d].ptr   = 0;
            m[d].valid = 1'b0;
            m[d].pkt   = '0;
            m[d].gmask = '0;
        end else if (!m[d].valid || !get_wi(d)) begin
            for (int k = 0; k < n; k++) begin
                int idx;
                idx = (m[d].ptr + k) % n;
                if (w < 0 && acc[idx]) w = idx;
            end
            if (w >= 0) begin
                m[d].valid = 1'b1;
                m[d].pkt   = get_pkt(d, w);
                m[d].gmask = 8'(1) << w;
                m[d].ptr   = (w + 1) % n;
            end else begin
                m[d].valid = 1'b0;
                m[d].gmask = '0;
            end
        end
        ew = (w >= 0) ? (acc & ~(8'(1) << w)) : acc;
    endtask

    // One clock: combinational wait_out checked at the falling edge, registered
    // outputs checked 1 time unit after the rising edge.
    task automatic step();
        logic [7:0] ew;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_eval(d, ew);
            check($sformatf("d%0d wait_out", d),
                  (d == 0) ? 104'(a_if.wait_out) : 104'(b_if.wait_out), 104'(ew));
        end
        @(posedge clk);
        #1;
        check("d0 access_out", 104'(a_if.access_out), 104'(m[0].valid));
        check("d0 grant_out",  104'(a_if.grant_out),  104'(m[0].gmask));
        check("d0 packet_out", 104'(a_if.packet_out), m[0].pkt);
        check("d1 access_out", 104'(b_if.access_out), 104'(m[1].valid));
        check("d1 grant_out",  104'(b_if.grant_out),  104'(m[1].gmask));
        check("d1 packet_out", 104'(b_if.packet_out), m[1].pkt);
    endtask

    task automatic drive(input logic [1:0] acc_a, input logic wi_a,
                         input logic [3:0] acc_b, input logic wi_b);
        a_if.access_in = acc_a;
        a_if.wait_in   = wi_a;
        b_if.access_in = acc_b;
        b_if.wait_in   = wi_b;
    endtask

    task automatic randomize_packets();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        a_if.packet_in = r[2*PW_A-1:0];
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        b_if.packet_in = r[4*PW_B-1:0];
    endtask

    localparam logic [103:0] P0 = 104'h11_2222_3333_4444_5555_6666_7777;
    localparam logic [103:0] P1 = 104'h88_9999_aaaa_bbbb_cccc_dddd_eeee;

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();

        // Reset held with everyone requesting: nothing granted, all wait.
        reset = 1'b1;
        drive(2'b11, 1'b0, 4'b1111, 1'b0);
        randomize_packets();
        step();
        step();
        check("rst access_out", 104'(a_if.access_out), 104'(0));
        check("rst grant_out",  104'(a_if.grant_out),  104'(0));
        check("rst wait_out",   104'(a_if.wait_out),   104'(2'b11));

        // First grant after release goes to the lowest active index.
        reset = 1'b0;
        drive(2'b11, 1'b0, 4'b1110, 1'b0);
        step();
        check("first grant a", 104'(a_if.grant_out), 104'(1 << REQ_DMA));
        check("first grant b", 104'(b_if.grant_out), 104'(4'b0010));

        // Lone requester 0 streams 0xA..0xD with one-cycle latency.
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 1'b0, 4'b0000, 1'b0);
            a_if.packet_in = '0;
            a_if.packet_in[PW_A-1:0] = PW_A'(32'hA + k);
            step();
            check("single packet", 104'(a_if.packet_out), 104'(32'hA + k));
            check("single grant",  104'(a_if.grant_out),  104'(2'b01));
        end
        drive(2'b00, 1'b0, 4'b0000, 1'b0);
        step();

        // Reset pulse so contention starts from ptr=0, then 6 cycles of 11.
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_if.packet_in = {P1, P0};
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 1'b0, 4'b0000, 1'b0);
            step();
            check("contention grant", 104'(a_if.grant_out), (k % 2 == 0) ? 104'(2'b01) : 104'(2'b10));
        end

        // Stall: grant 0, hold 3 cycles, then 1 is granted as wait_in falls.
        drive(2'b11, 1'b0, 4'b0000, 1'b0);
        step();
        check("pre-stall packet", 104'(a_if.packet_out), P0);
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1'b1, 4'b0000, 1'b0);
            @(negedge clk);
            check("stall wait_out", 104'(a_if.wait_out), 104'(2'b11));
            @(posedge clk);
            #1;
            check("stall packet", 104'(a_if.packet_out), P0);
        end
        // The loop above bypassed the model; its state is unchanged by a stall.
        drive(2'b11, 1'b0, 4'b0000, 1'b0);
        step();
        check("unstall grant",  104'(a_if.grant_out),  104'(2'b10));
        check("unstall packet", 104'(a_if.packet_out), P1);

        // Wrap on the 4-way instance: park ptr at 3, then 1001 -> 3 then 0.
        drive(2'b00, 1'b0, 4'b0100, 1'b0);
        step();
        check("wrap setup", 104'(b_if.grant_out), 104'(4'b0100));
        drive(2'b00, 1'b0, 4'b1001, 1'b0);
        step();
        check("wrap grant 3", 104'(b_if.grant_out), 104'(4'b1000));
        step();
        check("wrap grant 0", 104'(b_if.grant_out), 104'(4'b0001));

        // Mid-transfer reset while stalled drops access_out immediately.
        drive(2'b01, 1'b0, 4'b0001, 1'b0);
        step();
        drive(2'b01, 1'b1, 4'b0001, 1'b1);
        step();
        check("stalled before rst", 104'(a_if.access_out), 104'(1));
        #2;
        reset = 1'b1;
        #1;
        check("async rst access a", 104'(a_if.access_out), 104'(0));
        check("async rst access b", 104'(b_if.access_out), 104'(0));
        check("async rst packet",   104'(a_if.packet_out), 104'(0));
        model_reset();
        step();
        reset = 1'b0;
        drive(2'b11, 1'b0, 4'b1010, 1'b0);
        step();
        check("post-rst grant a", 104'(a_if.grant_out), 104'(2'b01));
        check("post-rst grant b", 104'(b_if.grant_out), 104'(4'b0010));

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(2'($urandom), ($urandom_range(0, 2) == 0),
                  4'($urandom), ($urandom_range(0, 2) == 0));
            randomize_packets();
            step();
        end

        // Full load, no stall: every requester exactly once per N cycles.
        drive(2'b11, 1'b0, 4'b1111, 1'b0);
        step();
        for (int w = 0; w < 3; w++) begin
            logic [3:0] seen;
            seen = '0;
            for (int k = 0; k < N_B; k++) begin
                step();
                seen = seen | b_if.grant_out;
            end
            check("fairness window", 104'(seen), 104'(4'b1111));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edma_arb.md
EDMA_ARB -- requirements
Module: edma_arb

Interface
REQ-001 Parameter: AW, 32, address width.
REQ-002 Parameter: N, 2, number of requesters, legal range 2..8 (requester 0 = DMA datapath, requester 1 = register readback).
REQ-003 Localparam: PW, 2*AW+40, standard emesh packet width.
REQ-004 Port: clk  input  1  sole clock; all state is rising-edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: access_in  input  N  per-requester packet valid.
REQ-007 Port: packet_in  input  N*PW  requester i occupies bits [i*PW+PW-1 : i*PW].
REQ-008 Port: wait_out  output  N  per-requester stall; requester holds access_in and packet_in while its bit is high.
REQ-009 Port: access_out  output  1  registered output valid.
REQ-010 Port: packet_out  output  PW  registered output packet.
REQ-011 Port: wait_in  input  1  downstream stall.
REQ-012 Port: grant_out  output  N  one-hot, registered; requester whose packet currently sits in the output register.

Function
REQ-013 Output register "load" SHALL be ~access_out | ~wait_in; the output register is free when it is empty or downstream accepts this cycle.
REQ-014 Requester i is "granted" in a cycle when load=1, access_in[i]=1, and i is the first requester with access_in set, searching upward modulo N from pointer ptr.
REQ-015 At most one requester is granted per cycle; the grant vector is one-hot or zero.
REQ-016 wait_out[i] SHALL be access_in[i] & ~granted[i], combinational, with no dependency on packet_in.
REQ-017 On load with a grant to i, the next edge SHALL set access_out=1, packet_out=packet_in[i], grant_out=one-hot(i), and ptr=(i+1) mod N.
REQ-018 On load with no access_in asserted, the next edge SHALL clear access_out and grant_out; packet_out and ptr hold.
REQ-019 While access_out=1 and wait_in=1, access_out, packet_out, grant_out and ptr SHALL hold, and all wait_out bits are set for active requesters.
REQ-020 Latency: packet_in to packet_out is exactly 1 cycle when unstalled; back-to-back packets are sustained at 1 per cycle.
REQ-021 ptr wraps from N-1 to 0; a lone requester SHALL be granted every cycle regardless of ptr.
REQ-022 Fairness: with all N requesters continuously asserted and wait_in=0, each requester is granted exactly once in every N consecutive cycles.
REQ-023 State machine, 2 bits (the encoding belongs in the package).
- IDLE (access_out=0) -> SEND on any grant.
- SEND -> STALL when wait_in=1.
- SEND -> IDLE when load with no request.
- STALL -> SEND when wait_in falls; the stalled packet completes that cycle and a new grant is allowed in the same cycle.
REQ-024 Simultaneous wait_in deassert and new request in STALL: the new grant SHALL be taken in the same cycle, with no bubble.
REQ-025 Packet contents are passed unmodified; no field is decoded.

Reset
REQ-026 During reset, access_out=0, packet_out=0, grant_out=0, ptr=0 and state=IDLE.
REQ-027 Reset asserted mid-transfer SHALL drop access_out asynchronously; the in-flight packet is discarded.
REQ-028 First grant after reset release goes to the lowest-index active requester.

Structure
REQ-029 Package edma_pkg holds the FSM state encoding (IDLE/SEND/STALL), the PW derivation and the requester index constants (REQ_DMA=0, REQ_REG=1).
REQ-030 One sub-module, oh_rrarb, SHALL implement the rotating-priority one-hot selector (inputs: request vector, ptr; output: grant vector); edma_arb instantiates it.

Verification
REQ-031 Reset: reset=1 with access_in=2'b11 -> access_out=0, grant_out=0, wait_out=2'b11.
REQ-032 Single requester: access_in=2'b01 for 4 cycles with packet 0xA..0xD, wait_in=0 -> packet_out shows 0xA..0xD on cycles 1..4 and grant_out=2'b01.
REQ-033 Contention: access_in=2'b11 held 6 cycles, wait_in=0 -> grant_out alternates 01,10,01,10,01,10 and each wait_out bit is high on alternate cycles.
REQ-034 Stall: wait_in=1 for 3 cycles while access_out=1 -> packet_out is stable for 3 cycles, wait_out=2'b11, and the next grant appears in the cycle wait_in falls.
REQ-035 Wrap: N=4, ptr=3, access_in=4'b1001 -> grant to 3, then ptr=0 and grant to 0.
REQ-036 Mid-transfer reset: reset pulsed while in STALL -> access_out=0 immediately; after release, first grant goes to requester 0.
